beta_instr_monitor: RTL

Passive receive-side monitor for the Beta instruction bus. It samples the 32-bit `INSTR` word that the stimulus driver places on `beta_if` and decodes it into `op`, `src1`, `src2`, `dest` and a literal, then classifies the opcode. Decoded transactions are buffered in a small FIFO and presented to the scoreboard over a valid/ready port. Running counters give coverage and error visibility. The block never drives the instruction bus.

---
 rtl/my_pkg.sv | 60 ++++++
 rtl/beta_mon_fifo.sv | 47 ++++
 rtl/beta_instr_monitor.sv | 105 ++++++++++
 3 files changed

// File: rtl/my_pkg.sv
// Shared Beta bus types: raw instruction layout, decoded monitor transaction
// and the opcode classifier used by the receive-side monitor.
package my_pkg;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [4:0]  dest;
    logic [10:0] unused;
  } inst_reg;

  typedef enum logic [3:0] {
    CLS_ALU     = 4'd0,
    CLS_ALUC    = 4'd1,
    CLS_LD      = 4'd2,
    CLS_ST      = 4'd3,
    CLS_JMP     = 4'd4,
    CLS_BEQ     = 4'd5,
    CLS_BNE     = 4'd6,
    CLS_LDR     = 4'd7,
    CLS_ILLEGAL = 4'd15
  } instr_class_e;

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;

  typedef struct packed {
    inst_reg      instr;
    logic [31:0]  lit;
    instr_class_e cls;
    logic         illegal;
  } mon_txn_t;

  // 0x20-0x2F are register ALU ops, 0x30-0x3F their constant forms.
  function automatic instr_class_e decode_op(input logic [5:0] op);
    instr_class_e cls;
    if (op[5:4] == 2'b10) begin
      cls = CLS_ALU;
    end else if (op[5:4] == 2'b11) begin
      cls = CLS_ALUC;
    end else begin
      case (op)
        OP_LD:   cls = CLS_LD;
        OP_ST:   cls = CLS_ST;
        OP_JMP:  cls = CLS_JMP;
        OP_BEQ:  cls = CLS_BEQ;
        OP_BNE:  cls = CLS_BNE;
        OP_LDR:  cls = CLS_LDR;
        default: cls = CLS_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/beta_mon_fifo.sv
// Show-ahead synchronous FIFO of decoded monitor transactions; a push into a
// full FIFO is accepted only when a pop frees a slot on the same edge.
module beta_mon_fifo
  import my_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  mon_txn_t din,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output mon_txn_t head
);

  localparam int AW = $clog2(DEPTH);

  mon_txn_t       mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Extra MSB on each pointer separates full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/beta_instr_monitor.sv
// Passive Beta instruction-bus monitor: capture, decode, classify and buffer
// each sampled word for the scoreboard, with coverage/error counters.
module beta_instr_monitor
  import my_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INSTR,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_op,
  output logic [4:0]  out_src1,
  output logic [4:0]  out_src2,
  output logic [4:0]  out_dest,
  output logic [31:0] out_lit,
  output logic [3:0]  out_class,
  output logic        out_illegal,
  output logic [31:0] inst_cnt,
  output logic [15:0] illegal_cnt,
  output logic [15:0] drop_cnt
);

  logic        arm;
  logic        cap_vld;
  logic [31:0] cap_word;
  mon_txn_t    dec_txn;
  mon_txn_t    head;
  mon_txn_t    view;
  logic        decode_en;
  logic        pop_req;
  logic        push_ok;
  logic        full;
  logic        empty;
  logic [10:0] unused_bits;

  // arm lags reset release by one edge so the stale reset-time bus word is never sampled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      arm      <= 1'b0;
      cap_vld  <= 1'b0;
      cap_word <= '0;
    end else begin
      arm     <= 1'b1;
      cap_vld <= arm;
      if (arm) cap_word <= INSTR;
    end
  end

  always_comb begin
    dec_txn         = '0;
    dec_txn.instr   = inst_reg'(cap_word);
    dec_txn.lit     = {{16{cap_word[15]}}, cap_word[15:0]};
    dec_txn.cls     = decode_op(cap_word[31:26]);
    dec_txn.illegal = (decode_op(cap_word[31:26]) == CLS_ILLEGAL);
  end

  assign decode_en = cap_vld && !(SKIP_ZERO && (cap_word == '0));

  // Output handshake: a transaction transfers on every rising edge where
  // out_valid && out_ready; while out_valid is high and out_ready low the
  // out_* fields hold the same head entry.
  assign pop_req = out_valid && out_ready;
  assign push_ok = decode_en && (!full || pop_req);

  beta_mon_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (decode_en),
    .din   (dec_txn),
    .pop   (pop_req),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      inst_cnt    <= '0;
      illegal_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (push_ok) inst_cnt <= inst_cnt + 32'd1;
      if (decode_en && dec_txn.illegal && (illegal_cnt != 16'hFFFF))
        illegal_cnt <= illegal_cnt + 16'd1;
      if (decode_en && !push_ok && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Fields read as zero whenever nothing is queued, including after reset.
  assign out_valid   = !empty;
  assign view        = out_valid ? head : '0;
  assign out_op      = view.instr.op;
  assign out_src1    = view.instr.src1;
  assign out_src2    = view.instr.src2;
  assign out_dest    = view.instr.dest;
  assign out_lit     = view.lit;
  assign out_class   = view.cls;
  assign out_illegal = view.illegal;
  assign unused_bits = view.instr.unused;

endmodule
